// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state encoding and sizing helpers for the p2s_stream serialiser.
// Build with P2S_PARITY_EN defined to append an even-parity bit to every word.
package p2s_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`ifdef P2S_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    function automatic int cnt_width(int width, int parity);
        return $clog2(width + parity);
    endfunction
endpackage

// File: rtl/p2s_bit_counter.sv
// p2s_bit_counter: beat counter with sync clear/enable and terminal count at NBITS-1.
module p2s_bit_counter #(
    parameter int NBITS = 4,
    parameter int CW    = 2
) (
    input  logic          clk_sig,
    input  logic          reset_sig,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);
    assign tc = (cnt == CW'(NBITS - 1));

    // Wrap to zero on the terminal beat so an idle counter always reads 0.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig)
            cnt <= '0;
        else if (clr || (en && tc))
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/p2s_stream.sv
// p2s_stream: valid/ready parallel-to-serial converter with selectable bit order.
// Optional even-parity bit per word when P2S_PARITY_EN is defined.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic [WIDTH-1:0] parallel_sig,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_sig,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_last
);
    localparam int NBITS = WIDTH + PARITY_BITS;
    localparam int CW    = cnt_width(WIDTH, PARITY_BITS);

    if (WIDTH < 2) begin : g_width_chk
        $error("p2s_stream: WIDTH must be >= 2");
    end

    state_t           state, state_nxt;
    logic [NBITS-1:0] sreg, load_val;
    logic [WIDTH-1:0] ordered;
    logic [CW-1:0]    bit_cnt;
    logic             tc, word_acc, bit_acc, last_q;

    assign bit_acc      = serial_valid && serial_ready;
    assign in_ready     = (state == IDLE) || (bit_acc && tc);
    assign word_acc     = in_valid && in_ready;
    assign serial_sig   = sreg[NBITS-1];
    assign serial_valid = (state == SHIFT);
    assign serial_last  = last_q;

    // The first bit out is always the shift-register MSB, so LSB-first words are reversed on load.
    always_comb begin
        ordered = parallel_sig;
        if (!MSB_FIRST)
            for (int i = 0; i < WIDTH; i++)
                ordered[i] = parallel_sig[WIDTH-1-i];
    end

`ifdef P2S_PARITY_EN
    assign load_val = {ordered, ^parallel_sig};
`else
    assign load_val = ordered;
`endif

    always_comb begin
        state_nxt = state;
        if (word_acc)
            state_nxt = SHIFT;
        else if (bit_acc && tc)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Zeros shift in behind the word, so the register is empty again once idle.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            sreg   <= '0;
            last_q <= 1'b0;
        end else if (word_acc) begin
            sreg   <= load_val;
            last_q <= 1'b0;
        end else if (bit_acc) begin
            sreg   <= {sreg[NBITS-2:0], 1'b0};
            last_q <= (bit_cnt == CW'(NBITS - 2));
        end
    end

    p2s_bit_counter #(.NBITS(NBITS), .CW(CW)) u_cnt (
        .clk_sig  (clk_sig),
        .reset_sig(reset_sig),
        .clr      (word_acc),
        .en       (bit_acc),
        .cnt      (bit_cnt),
        .tc       (tc)
    );
endmodule

// File: tb/tb_p2s_stream.sv
// tb_p2s_stream: directed self-checking bench driving an MSB-first and an LSB-first instance in lockstep.
module tb_p2s_stream;
`ifdef P2S_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data = '0;
    logic       in_valid = 1'b0;
    logic       serial_ready = 1'b0;
    logic       rdy_m, sig_m, val_m, last_m;
    logic       rdy_l, sig_l, val_l, last_l;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    p2s_stream #(.WIDTH(4), .MSB_FIRST(1)) u_m (
        .clk_sig(clk), .reset_sig(rst_n), .parallel_sig(data), .in_valid(in_valid),
        .in_ready(rdy_m), .serial_sig(sig_m), .serial_valid(val_m),
        .serial_ready(serial_ready), .serial_last(last_m)
    );
    p2s_stream #(.WIDTH(4), .MSB_FIRST(0)) u_l (
        .clk_sig(clk), .reset_sig(rst_n), .parallel_sig(data), .in_valid(in_valid),
        .in_ready(rdy_l), .serial_sig(sig_l), .serial_valid(val_l),
        .serial_ready(serial_ready), .serial_last(last_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic r);
        @(negedge clk);
        in_valid = v;
        data = d;
        serial_ready = r;
        #1;
    endtask

    function automatic logic ebit(input logic [3:0] w, input int pos, input bit msb);
        if (pos == 4) return ^w;
        return msb ? w[3-pos] : w[pos];
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_val_m"}, {7'd0, val_m}, 8'd0);
        chk({tag, "_sig_m"}, {7'd0, sig_m}, 8'd0);
        chk({tag, "_last_m"}, {7'd0, last_m}, 8'd0);
        chk({tag, "_val_l"}, {7'd0, val_l}, 8'd0);
        chk({tag, "_sig_l"}, {7'd0, sig_l}, 8'd0);
    endtask

    task automatic bit_chk(input string tag, input logic [3:0] w, input int pos, input logic rdy);
        chk({tag, "_val"}, {6'd0, val_m, val_l}, 8'h03);
        chk({tag, "_sig_m"}, {7'd0, sig_m}, {7'd0, ebit(w, pos, 1'b1)});
        chk({tag, "_sig_l"}, {7'd0, sig_l}, {7'd0, ebit(w, pos, 1'b0)});
        chk({tag, "_last"}, {6'd0, last_m, last_l}, (pos == NB - 1) ? 8'h03 : 8'h00);
        chk({tag, "_rdy"}, {6'd0, rdy_m, rdy_l}, rdy ? 8'h03 : 8'h00);
    endtask

    task automatic run_word(input string tag, input logic [3:0] w);
        cyc(1'b1, w, 1'b1);
        chk({tag, "_accept_rdy"}, {6'd0, rdy_m, rdy_l}, 8'h03);
        for (int p = 0; p < NB; p++) begin
            cyc(1'b0, 4'h0, 1'b1);
            bit_chk(tag, w, p, p == NB - 1);
        end
        cyc(1'b0, 4'h0, 1'b1);
        idle_chk({tag, "_done"});
    endtask

    initial begin
        #2;
        idle_chk("reset");
        chk("reset_cnt", {6'd0, u_m.bit_cnt}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_rdy", {6'd0, rdy_m, rdy_l}, 8'h03);

        run_word("w1011", 4'b1011);

        // Back-to-back A then 5: second word taken on A's last-bit cycle, no bubble.
        cyc(1'b1, 4'hA, 1'b1);
        for (int k = 0; k < 2 * NB; k++) begin
            cyc(k < NB, 4'h5, 1'b1);
            bit_chk("b2b", (k < NB) ? 4'hA : 4'h5, k % NB, (k % NB) == NB - 1);
        end
        cyc(1'b0, 4'h0, 1'b1);
        idle_chk("b2b_done");

        // Stall on the first bit of 4'hC.
        cyc(1'b1, 4'hC, 1'b1);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 4'h3, 1'b0);
            bit_chk("stall", 4'hC, 0, 1'b0);
            chk("stall_cnt", {6'd0, u_m.bit_cnt}, 8'd0);
        end
        for (int p = 0; p < NB; p++) begin
            cyc(1'b0, 4'h0, 1'b1);
            bit_chk("stall_rel", 4'hC, p, p == NB - 1);
        end
        cyc(1'b0, 4'h0, 1'b1);
        idle_chk("stall_done");

        run_word("w0111", 4'b0111);
        run_word("w0011", 4'b0011);

        // Asynchronous reset after two bits of 4'hF.
        cyc(1'b1, 4'hF, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);
        bit_chk("rstw", 4'hF, 0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1);
        bit_chk("rstw", 4'hF, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        idle_chk("async_rst");
        chk("async_rst_cnt", {6'd0, u_m.bit_cnt}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", {6'd0, rdy_m, rdy_l}, 8'h03);
        idle_chk("rel");
        run_word("w1001", 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
